// File: rtl/fetch_queue_pkg.sv
// Shared CPU constants: fetch increment, reset vector and base opcodes.
package fetch_queue_pkg;

   localparam logic [31:0] PC_INC           = 32'd4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [6:0] {
      OP_LOAD   = 7'b0000011,
      OP_IMM    = 7'b0010011,
      OP_AUIPC  = 7'b0010111,
      OP_STORE  = 7'b0100011,
      OP_REG    = 7'b0110011,
      OP_LUI    = 7'b0110111,
      OP_BRANCH = 7'b1100011,
      OP_JALR   = 7'b1100111,
      OP_JAL    = 7'b1101111
   } opcode_e;

   function automatic logic [6:0] opcode_of(input logic [31:0] inst);
      return inst[6:0];
   endfunction

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Synchronous FIFO with clear; storage is not reset, only pointers and count.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clear,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear && !reset) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: fetch-PC sequencing and redirect around a sync_fifo
// holding {instruction, pc+4} entries.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int                DATA_W   = 32,
   parameter int                ADDR_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic [ADDR_W-1:0]      redirect_pc,
   output logic [ADDR_W-1:0]      mem_addr,
   input  logic [DATA_W-1:0]      mem_rdata,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_inst,
   output logic [ADDR_W-1:0]      out_pc_plus_4,
   output logic [$clog2(DEPTH):0] count
);

   localparam int                CNT_W    = $clog2(DEPTH) + 1;
   localparam int                ENTRY_W  = DATA_W + ADDR_W;
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
   localparam logic [ADDR_W-1:0] INC      = ADDR_W'(PC_INC);

   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [ADDR_W-1:0]  pc_plus_4_s;
   logic               push_s, pop_s;
   logic [ENTRY_W-1:0] wdata_s, rdata_s;
   logic [CNT_W-1:0]   count_s;

   // out_ready only reaches pc_d, never mem_addr, which comes straight from pc_q.
   always_comb begin
      pc_plus_4_s = pc_q + INC;
      pop_s       = (count_s != '0) && out_ready && !flush;
      push_s      = ((count_s < FULL_CNT) || pop_s) && !flush;
      wdata_s     = {mem_rdata, pc_plus_4_s};
      if (flush) begin
         pc_d = redirect_pc;
      end else if (push_s) begin
         pc_d = pc_plus_4_s;
      end else begin
         pc_d = pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_s),
      .pop   (pop_s),
      .clear (flush),
      .wdata (wdata_s),
      .rdata (rdata_s),
      .count (count_s)
   );

   assign mem_addr      = pc_q;
   assign out_valid     = (count_s != '0);
   assign out_inst      = rdata_s[ENTRY_W-1:ADDR_W];
   assign out_pc_plus_4 = rdata_s[ADDR_W-1:0];
   assign count         = count_s;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a fetch model queues expected entries,
// a negedge monitor pops and compares them, directed phases add fixed checks.
module tb_fetch_queue;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset, flush, out_ready, out_valid;
   logic [31:0] redirect_pc, mem_addr, mem_rdata, out_inst, out_pc_plus_4;
   logic [2:0]  count;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc4;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] m_pc;
   logic        chk_en = 1'b0;
   int          n_cmp = 0;
   int          n_bad = 0;

   function automatic logic [31:0] tb_mem(input logic [31:0] addr);
      return addr ^ 32'hDEAD_BEEF;
   endfunction

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endfunction

   fetch_queue dut (
      .clk           (clk),
      .reset         (reset),
      .flush         (flush),
      .redirect_pc   (redirect_pc),
      .mem_addr      (mem_addr),
      .mem_rdata     (mem_rdata),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_inst      (out_inst),
      .out_pc_plus_4 (out_pc_plus_4),
      .count         (count)
   );

   always #5 clk = ~clk;

   assign mem_rdata = tb_mem(mem_addr);

   // Fetch model: on each edge, queue the word the DUT should be capturing.
   always @(posedge clk) begin
      if (reset) begin
         exp_q.delete();
         m_pc = RST_PC;
      end else if (flush) begin
         exp_q.delete();
         m_pc = redirect_pc;
      end else if (exp_q.size() < 4) begin
         exp_q.push_back('{inst: tb_mem(m_pc), pc4: m_pc + 32'd4});
         m_pc = m_pc + 32'd4;
      end
   end

   // Monitor: pops the expected head whenever a handshake is due this cycle.
   always @(negedge clk) begin
      exp_t e;
      if (chk_en) begin
         check("sb_count", 32'(count), 32'(exp_q.size()));
         check("sb_out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
         check("sb_mem_addr", mem_addr, m_pc);
         if (!reset && !flush && out_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_head_inst", out_inst, e.inst);
            check("sb_head_pc4", out_pc_plus_4, e.pc4);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int cnt_seq[6];
      cnt_seq = '{1, 2, 3, 4, 4, 4};
      reset = 1'b1; flush = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
      step();
      chk_en = 1'b1;
      step();
      check("rst_count", 32'(count), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      reset = 1'b0;
      check("rst_mem_addr", mem_addr, RST_PC);

      // Fill with decode stalled.
      for (int i = 0; i < 6; i++) begin
         step();
         check("fill_count", 32'(count), 32'(cnt_seq[i]));
      end
      check("fill_mem_addr", mem_addr, 32'h10);
      check("fill_head_pc4", out_pc_plus_4, 32'h4);
      check("fill_head_inst", out_inst, 32'hDEAD_BEEF);

      // Streaming while full.
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("stream_pc4", out_pc_plus_4, 32'(4 * (i + 1)));
         check("stream_count", 32'(count), 32'd4);
         step();
      end

      // Redirect while full with decode ready.
      flush = 1'b1; redirect_pc = 32'h40;
      step();
      flush = 1'b0;
      check("flush_count", 32'(count), 32'd0);
      check("flush_valid", 32'(out_valid), 32'd0);
      check("flush_mem_addr", mem_addr, 32'h40);
      step();
      check("redir_valid", 32'(out_valid), 32'd1);
      check("redir_pc4", out_pc_plus_4, 32'h44);
      check("redir_inst", out_inst, 32'h40 ^ 32'hDEAD_BEEF);

      // Alternating ready exercises pointer wrap.
      for (int i = 0; i < 10; i++) begin
         out_ready = (i % 2 == 0);
         step();
      end
      check("wrap_count", 32'(count), 32'd4);
      check("wrap_head_pc4", out_pc_plus_4, 32'h58);
      check("wrap_mem_addr", mem_addr, 32'h64);

      // Reset beats flush with three entries queued.
      out_ready = 1'b0; flush = 1'b1; redirect_pc = 32'h100;
      step();
      flush = 1'b0;
      for (int i = 0; i < 3; i++) step();
      check("pre_rst_count", 32'(count), 32'd3);
      reset = 1'b1; flush = 1'b1; redirect_pc = 32'h200;
      step();
      reset = 1'b0; flush = 1'b0;
      check("rst_flush_count", 32'(count), 32'd0);
      check("rst_flush_valid", 32'(out_valid), 32'd0);
      check("rst_flush_mem_addr", mem_addr, RST_PC);

      // Fetch PC wraps at the top of the address space.
      flush = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      step();
      flush = 1'b0;
      check("top_mem_addr", mem_addr, 32'hFFFF_FFFC);
      step();
      check("top_head_pc4", out_pc_plus_4, 32'h0000_0000);
      check("top_head_inst", out_inst, 32'hFFFF_FFFC ^ 32'hDEAD_BEEF);
      check("top_mem_wrap", mem_addr, 32'h0000_0000);
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
